// File: rtl/morra_match_sequencer.sv
// morra_match_sequencer: runs one morra cinese match on the game core.
// It configures the core, collects one move per player through independent
// valid/ready slots, issues each pair for one cycle, then counts rounds and
// holds the final outcome until the next start.
module morra_match_sequencer #(
  parameter int unsigned BASE_ROUNDS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] cfg_extra,
  input  logic       p1_valid,
  input  logic [1:0] p1_move,
  output logic       p1_ready,
  input  logic       p2_valid,
  input  logic [1:0] p2_move,
  output logic       p2_ready,
  output logic       core_reset,
  output logic [1:0] core_primo,
  output logic [1:0] core_secondo,
  input  logic [1:0] core_manche,
  input  logic [1:0] core_partita,
  output logic       busy,
  output logic       round_done,
  output logic [1:0] round_result,
  output logic       rejected,
  output logic [4:0] round_count,
  output logic       match_done,
  output logic [1:0] match_result
);

  localparam logic [4:0] BASE5 = 5'(BASE_ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_COLLECT,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t     state;
  logic [1:0] slot1;
  logic [1:0] slot2;
  logic       full1;
  logic       full2;
  logic [4:0] cap;

  logic       acc1;
  logic       acc2;
  logic       full1_n;
  logic       full2_n;
  logic [4:0] count_inc;

  // Acceptance per player and slot occupancy as it will be after this edge.
  always_comb begin
    acc1      = (state == S_COLLECT) && p1_valid && p1_ready;
    acc2      = (state == S_COLLECT) && p2_valid && p2_ready;
    full1_n   = full1 | acc1;
    full2_n   = full2 | acc2;
    count_inc = round_count + 5'd1;
  end

  // Match sequencing; every output is registered and reflects the state entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      slot1        <= '0;
      slot2        <= '0;
      full1        <= 1'b0;
      full2        <= 1'b0;
      cap          <= '0;
      p1_ready     <= 1'b0;
      p2_ready     <= 1'b0;
      core_reset   <= 1'b0;
      core_primo   <= '0;
      core_secondo <= '0;
      busy         <= 1'b0;
      round_done   <= 1'b0;
      round_result <= '0;
      rejected     <= 1'b0;
      round_count  <= '0;
      match_done   <= 1'b0;
      match_result <= '0;
    end else begin
      round_done <= 1'b0;
      rejected   <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_CONFIG;
            cap          <= BASE5 + {1'b0, cfg_extra};
            round_count  <= '0;
            match_result <= '0;
            match_done   <= 1'b0;
            busy         <= 1'b1;
            core_reset   <= 1'b1;
            core_primo   <= cfg_extra[3:2];
            core_secondo <= cfg_extra[1:0];
          end
        end
        S_CONFIG: begin
          core_reset   <= 1'b0;
          core_primo   <= '0;
          core_secondo <= '0;
          p1_ready     <= 1'b1;
          p2_ready     <= 1'b1;
          state        <= S_COLLECT;
        end
        S_COLLECT: begin
          if (acc1) begin
            slot1 <= p1_move;
            full1 <= 1'b1;
          end
          if (acc2) begin
            slot2 <= p2_move;
            full2 <= 1'b1;
          end
          p1_ready <= ~full1_n;
          p2_ready <= ~full2_n;
          // The issued pair comes from the slot or, if accepted on this edge, the bus.
          if (full1_n && full2_n) begin
            state        <= S_ISSUE;
            core_primo   <= acc1 ? p1_move : slot1;
            core_secondo <= acc2 ? p2_move : slot2;
          end
        end
        S_ISSUE: begin
          core_primo   <= '0;
          core_secondo <= '0;
          slot1        <= '0;
          slot2        <= '0;
          full1        <= 1'b0;
          full2        <= 1'b0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (core_manche == 2'b00) begin
            rejected <= 1'b1;
            p1_ready <= 1'b1;
            p2_ready <= 1'b1;
            state    <= S_COLLECT;
          end else begin
            round_count  <= count_inc;
            round_result <= core_manche;
            round_done   <= 1'b1;
            if (core_partita != 2'b00) begin
              match_result <= core_partita;
              match_done   <= 1'b1;
              busy         <= 1'b0;
              state        <= S_DONE;
            end else if (count_inc >= cap) begin
              match_result <= 2'b11;
              match_done   <= 1'b1;
              busy         <= 1'b0;
              state        <= S_DONE;
            end else begin
              p1_ready <= 1'b1;
              p2_ready <= 1'b1;
              state    <= S_COLLECT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morra_match_sequencer.sv
// Scoreboard bench for morra_match_sequencer: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_morra_match_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] cfg_extra = '0;
  logic       p1_valid = 1'b0;
  logic [1:0] p1_move = '0;
  logic       p1_ready;
  logic       p2_valid = 1'b0;
  logic [1:0] p2_move = '0;
  logic       p2_ready;
  logic       core_reset;
  logic [1:0] core_primo;
  logic [1:0] core_secondo;
  logic [1:0] core_manche = '0;
  logic [1:0] core_partita = '0;
  logic       busy;
  logic       round_done;
  logic [1:0] round_result;
  logic       rejected;
  logic [4:0] round_count;
  logic       match_done;
  logic [1:0] match_result;

  morra_match_sequencer #(.BASE_ROUNDS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_extra(cfg_extra),
    .p1_valid(p1_valid), .p1_move(p1_move), .p1_ready(p1_ready),
    .p2_valid(p2_valid), .p2_move(p2_move), .p2_ready(p2_ready),
    .core_reset(core_reset), .core_primo(core_primo), .core_secondo(core_secondo),
    .core_manche(core_manche), .core_partita(core_partita),
    .busy(busy), .round_done(round_done), .round_result(round_result),
    .rejected(rejected), .round_count(round_count),
    .match_done(match_done), .match_result(match_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int K_CFG = 0, K_ISS = 1, K_RND = 2, K_REJ = 3;
  typedef struct {
    int kind;
    int a, b, c, d, e, f;
    int cyc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int exp_count = 0;
  int cap_exp = 0;
  logic [1:0] resp_m = '0;
  logic [1:0] resp_p = '0;
  bit pend = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int kind, input int a, input int b, input int c,
                      input int d, input int e, input int f, input int ecyc);
    exp_t x;
    x.kind = kind; x.a = a; x.b = b; x.c = c; x.d = d; x.e = e; x.f = f; x.cyc = ecyc;
    q.push_back(x);
  endtask

  // Bench model of the core: answers one cycle after it sees an issued pair.
  always @(negedge clk) begin
    core_manche  = pend ? resp_m : 2'b00;
    core_partita = pend ? resp_p : 2'b00;
    pend = !core_reset && (core_primo != 2'b00 || core_secondo != 2'b00);
  end

  task automatic handle(input int kind);
    exp_t x;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event actual_kind=%0d expected=none (cycle %0d)", kind, cyc);
      return;
    end
    x = q.pop_front();
    chk("event_kind", kind, x.kind);
    if (kind != x.kind) return;
    case (kind)
      K_CFG: begin
        chk("cfg_primo", int'(core_primo), x.a);
        chk("cfg_secondo", int'(core_secondo), x.b);
        chk("cfg_busy", int'(busy), x.c);
        chk("cfg_round_count", int'(round_count), x.d);
        chk("cfg_match_done", int'(match_done), x.e);
        chk("cfg_match_result", int'(match_result), x.f);
      end
      K_ISS: begin
        chk("issue_primo", int'(core_primo), x.a);
        chk("issue_secondo", int'(core_secondo), x.b);
      end
      K_RND: begin
        chk("round_result", int'(round_result), x.a);
        chk("round_count", int'(round_count), x.b);
        chk("match_done", int'(match_done), x.c);
        chk("match_result", int'(match_result), x.d);
        chk("round_busy", int'(busy), x.e);
        chk("round_ready", int'({p1_ready, p2_ready}), x.f);
      end
      default: begin
        chk("rej_round_count", int'(round_count), x.a);
        chk("rej_ready", int'({p1_ready, p2_ready}), x.b);
        chk("rej_busy", int'(busy), x.c);
      end
    endcase
    chk("event_cycle", cyc, x.cyc);
  endtask

  // Monitor: every DUT event must match the head of the expectation queue.
  always @(negedge clk) begin
    if (core_reset === 1'b1) handle(K_CFG);
    if (core_reset === 1'b0 && (core_primo != 2'b00 || core_secondo != 2'b00)) handle(K_ISS);
    if (round_done === 1'b1) handle(K_RND);
    if (rejected === 1'b1) handle(K_REJ);
  end

  function automatic logic [19:0] all_outs();
    return {p1_ready, p2_ready, core_reset, core_primo, core_secondo, busy, round_done,
            round_result, rejected, round_count, match_done, match_result};
  endfunction

  task automatic start_match(input logic [3:0] cfg);
    @(negedge clk);
    start = 1'b1;
    cfg_extra = cfg;
    push(K_CFG, int'(cfg[3:2]), int'(cfg[1:0]), 1, 0, 0, 0, cyc + 1);
    exp_count = 0;
    cap_exp = 4 + int'(cfg);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ready_after_cfg", int'({p1_ready, p2_ready}), 3);
    chk("busy_after_cfg", int'(busy), 1);
  endtask

  // One round: p1 offered from cycle d1, p2 from d2; p1 may keep offering alt after acceptance.
  task automatic play(input logic [1:0] m1, input logic [1:0] m2, input int d1, input int d2,
                      input bit hold, input logic [1:0] alt, input logic [1:0] rm,
                      input logic [1:0] rp, input bit rst_in_wait);
    int t = 0;
    bit done1 = 0, done2 = 0, fin;
    int c0;
    resp_m = rm;
    resp_p = rp;
    while (!(done1 && done2)) begin
      @(negedge clk);
      if (t > 60) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=not_accepted expected=accepted (cycle %0d)", cyc);
        p1_valid = 1'b0;
        p2_valid = 1'b0;
        return;
      end
      if (done1) chk("p1_ready_after_accept", int'(p1_ready), 0);
      p1_valid = (!done1 && t >= d1) || (done1 && hold);
      p1_move  = done1 ? alt : m1;
      p2_valid = !done2 && t >= d2;
      p2_move  = m2;
      if (!done1 && p1_valid && p1_ready) done1 = 1;
      if (!done2 && p2_valid && p2_ready) done2 = 1;
      t++;
    end
    c0 = cyc + 1;
    push(K_ISS, int'(m1), int'(m2), 0, 0, 0, 0, c0);
    if (!rst_in_wait) begin
      if (rm == 2'b00) begin
        push(K_REJ, exp_count, 3, 1, 0, 0, 0, c0 + 2);
      end else begin
        exp_count++;
        fin = (rp != 2'b00) || (exp_count >= cap_exp);
        push(K_RND, int'(rm), exp_count, int'(fin), fin ? (rp != 2'b00 ? int'(rp) : 3) : 0,
             fin ? 0 : 1, fin ? 0 : 3, c0 + 2);
      end
    end
    @(negedge clk);
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    @(negedge clk);
    if (rst_in_wait) reset = 1'b1;
    @(negedge clk);
    if (rst_in_wait) begin
      chk("outputs_after_reset_in_wait", int'(all_outs()), 0);
      reset = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("outputs_after_reset", int'(all_outs()), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", int'(all_outs()), 0);

    // Match 1: cap 10, ends on core partita 01.
    start_match(4'b0110);
    play(2'b01, 2'b11, 0, 0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
    play(2'b10, 2'b01, 0, 5, 1'b1, 2'b11, 2'b11, 2'b00, 1'b0);
    play(2'b11, 2'b11, 0, 0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    play(2'b01, 2'b11, 2, 0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
    play(2'b10, 2'b01, 0, 1, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      p1_valid = 1'b1; p1_move = 2'b01;
      p2_valid = 1'b1; p2_move = 2'b10;
      chk("ready_in_done", int'({p1_ready, p2_ready}), 0);
    end
    @(negedge clk);
    p1_valid = 1'b0;
    p2_valid = 1'b0;
    chk("done_hold_match_done", int'(match_done), 1);
    chk("done_hold_match_result", int'(match_result), 1);
    chk("done_hold_busy", int'(busy), 0);

    // Match 2: cap 4, four ties force a draw.
    start_match(4'b0000);
    for (int i = 0; i < 4; i++)
      play(2'b01, 2'b01, 0, 0, 1'b0, 2'b00, 2'b11, 2'b00, 1'b0);
    chk("cap_match_result", int'(match_result), 3);
    chk("cap_round_count", int'(round_count), 4);

    // Match 3: reset lands in WAIT.
    start_match(4'b0001);
    play(2'b11, 2'b10, 0, 0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0);
    play(2'b01, 2'b10, 0, 0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b1);
    repeat (3) @(negedge clk);
    chk("idle_after_reset", int'(all_outs()), 0);
    chk("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/morra_match_sequencer.md
# morra_match_sequencer

Sequencer that runs one complete morra cinese (rock-paper-scissors) match on the existing game core. Each match starts with a one-cycle configuration pulse to the core. After that, the block collects one move per player through independent valid/ready channels and issues each move pair to the core for exactly one cycle. It reads back the round and match results, counts valid rounds, and holds the final match outcome until the next match starts. It sits between the player input logic and the game core and owns the core's reset, primo and secondo inputs.

## Interface
- BASE_ROUNDS, 4: minimum round count. Matches the core's fixed minimum. Round cap is BASE_ROUNDS + cfg_extra.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a match. Honoured only in IDLE or DONE.
- cfg_extra  in  4  extra rounds allowed beyond BASE_ROUNDS. Sampled on the start edge.
- p1_valid / p2_valid  in  1  player move offered.
- p1_move / p2_move  in  2  01 rock, 10 paper, 11 scissors, 00 none.
- p1_ready / p2_ready  out  1  slot for that player is empty and the block is collecting.
- core_reset  out  1  drives the core's reset.
- core_primo / core_secondo  out  2  move (or config nibble) driven to the core.
- core_manche  in  2  core round result: 00 rejected, 01 player 1, 10 player 2, 11 tie.
- core_partita  in  2  core match result: 00 ongoing, 01 player 1, 10 player 2, 11 draw.
- busy  out  1  high from the CONFIG cycle until entry to DONE.
- round_done  out  1  one-cycle pulse when a counted round completes.
- round_result  out  2  core_manche value of the last counted round.
- rejected  out  1  one-cycle pulse when the core returned 00 for an issued pair.
- round_count  out  5  number of counted rounds in the current match.
- match_done  out  1  level; high while in DONE.
- match_result  out  2  final outcome; valid while match_done is high.

## Operation
- States: IDLE, CONFIG, COLLECT, ISSUE, WAIT, DONE.
- Reset: state IDLE.
  - All outputs 0, core_primo/core_secondo 00, core_reset 0.
  - Move slots empty, round_count 0, stored cap 0.
- IDLE/DONE, start=1:
  - Go to CONFIG and latch cap = BASE_ROUNDS + cfg_extra (5-bit, max 19).
  - Clear round_count, match_result and match_done.
- CONFIG (1 cycle):
  - core_reset=1, core_primo=cfg_extra[3:2], core_secondo=cfg_extra[1:0], busy=1.
  - Next state COLLECT.
- COLLECT:
  - pN_ready = slot N empty.
  - On pN_valid & pN_ready, latch pN_move into slot N. The two players are independent and may be accepted in the same cycle.
  - When both slots are full after the edge, go to ISSUE.
  - A move value of 00 is accepted unchanged; the core rejects it.
- ISSUE (1 cycle): core_primo/core_secondo = slots. Clear both slots at the exit edge. Next state WAIT.
- WAIT (1 cycle): moves driven 00/00. Sample core_manche and core_partita at the exit edge.
  - manche=00: pulse rejected. round_count unchanged. Go to COLLECT; players resubmit.
  - manche≠00 and partita≠00: round_count+1, round_result=manche, pulse round_done. Go to DONE with match_result=partita.
  - manche≠00, partita=00, incremented round_count ≥ cap: same counting and pulse. Go to DONE with match_result=11 (forced draw).
  - Otherwise: count and pulse round_done, then return to COLLECT.
- DONE: match_done=1, busy=0, ready=0. Hold all results until start or reset.
- core_primo/core_secondo are 00 in every state except CONFIG and ISSUE. core_reset is 1 only in CONFIG.
- start is ignored in CONFIG, COLLECT, ISSUE and WAIT.
- Reset in any state returns to IDLE within one edge. Pending slots are discarded.

## Timing
- Start edge S0: CONFIG runs S0→S1; COLLECT begins at S1.
- Both moves accepted at edge E0:
  - ISSUE runs E0→E1.
  - WAIT runs E1→E2.
  - round_done/rejected are high E2→E3.
  - round_count, round_result, match_done and match_result update at E2.
- Best-case round-to-round throughput: 3 cycles.
- p1_ready and p2_ready drop in the cycle after each player's own acceptance.
- Player slots are single-entry; a second offer from the same player waits.

## Test plan
- Config: reset, then start with cfg_extra=0110 → one cycle with core_reset=1 and core_primo=01, core_secondo=10. busy rises. p1_ready=p2_ready=1 in the next cycle.
- Same-cycle accept: p1 01 and p2 11 valid together; bench core returns manche 01, partita 00 → core_primo=01/core_secondo=11 for exactly one cycle. round_done pulse 3 cycles after acceptance, round_result=01, round_count=1.
- Staggered accept: p1 offered 5 cycles before p2 → p1_ready low after its accept, ISSUE only after p2 is accepted, p1 slot value unchanged.
- Rejection: bench returns manche 00 → rejected pulse, round_count unchanged, both ready high again.
- Match end: fourth counted round with core_partita=01 → match_done=1, match_result=01, busy=0. Further offers are not accepted.
- Cap and reset: cfg_extra=0000, four counted tie rounds with partita 00 → match_result=11. Reset asserted mid-WAIT → IDLE and all outputs 0 next cycle.
